// File: rtl/pulse_tx_sched.sv
// pulse_tx_sched
//   Schedules words from two requesters onto one single-wire pulse line.
//   Round-robin arbitration picks a requester in IDLE. The granted word is
//   then framed as: start bit (0), DATA_W data bits LSB first, stop bit (1),
//   and GAP_BITS idle-high bit times. Each bit lasts BIT_CYCLES clocks.
//
// Handshake: a word transfers on the rising edge where reqN_valid && reqN_ready.
//   ready is combinational and may depend on valid. valid must not depend on ready.
//   At most one ready is high, and only in IDLE while rst is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/data/ready    requester 0 handshake
//   req1_valid/data/ready    requester 1 handshake
//   pulse_out                registered serial line, idle high
//   busy                     registered, high while state != IDLE
//   grant_id                 registered, owner of current/last frame
//   state_dbg                current FSM state encoding, for checkers
module pulse_tx_sched #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int GAP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              pulse_out,
    output logic              busy,
    output logic              grant_id,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Counter widths are floored at 1 bit so degenerate parameters still elaborate.
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t            state, state_nx;
    logic [CW-1:0]     cyc_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              last_grant;
    logic              sel;
    logic              accept;
    logic              bit_end;
    logic              pulse_nx;

    assign bit_end   = (cyc_cnt == CYC_LAST);
    assign state_dbg = state;

    // On a tie, the requester that did not win last time gets the grant.
    assign sel    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_START;
            S_START: if (bit_end) state_nx = S_DATA;
            S_DATA:  if (bit_end && bit_cnt == BIT_LAST) state_nx = S_STOP;
            S_STOP:  if (bit_end) state_nx = (GAP_BITS > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (bit_end && gap_cnt == GAP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic: handshake readies. rst gates them so they drop immediately.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == S_IDLE) begin
            req0_ready = req0_valid && !sel;
            req1_ready = req1_valid && sel;
        end
    end

    // The line is registered from next-cycle values. This puts the start bit
    // on the wire in the first cycle after the accepting edge.
    always_comb begin
        shreg_nx = shreg;
        if (accept)
            shreg_nx = sel ? req1_data : req0_data;
        else if (state == S_DATA && bit_end)
            shreg_nx = shreg >> 1;
        case (state_nx)
            S_START: pulse_nx = 1'b0;
            S_DATA:  pulse_nx = shreg_nx[0];
            default: pulse_nx = 1'b1;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            pulse_out  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            shreg     <= shreg_nx;
            pulse_out <= pulse_nx;
            busy      <= (state_nx != S_IDLE);

            if (state == S_IDLE || bit_end) cyc_cnt <= '0;
            else                            cyc_cnt <= cyc_cnt + 1'b1;

            if (state == S_DATA && bit_end)
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

            if (state == S_GAP && bit_end)
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;

            if (accept) begin
                grant_id   <= sel;
                last_grant <= sel;
            end
        end
    end

endmodule

// File: tb/tb_pulse_tx_sched.sv
// Bench for pulse_tx_sched: a default-parameter instance and a
// DATA_W=8 / BIT_CYCLES=1 / GAP_BITS=0 corner instance.
module tb_pulse_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, pulse_out, busy, grant_id;
    logic [2:0] state_dbg;

    logic       c_req0_valid, c_req1_valid;
    logic [7:0] c_req0_data, c_req1_data;
    logic       c_req0_ready, c_req1_ready, c_pulse_out, c_busy, c_grant_id;
    logic [2:0] c_state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_tx_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .pulse_out(pulse_out), .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
    );

    pulse_tx_sched #(.DATA_W(8), .BIT_CYCLES(1), .GAP_BITS(0)) dut_c (
        .clk(clk), .rst(rst),
        .req0_valid(c_req0_valid), .req0_data(c_req0_data), .req0_ready(c_req0_ready),
        .req1_valid(c_req1_valid), .req1_data(c_req1_data), .req1_ready(c_req1_ready),
        .pulse_out(c_pulse_out), .busy(c_busy), .grant_id(c_grant_id), .state_dbg(c_state_dbg)
    );

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic [9:0] frame;   // {stop, data, start}, sent from bit 0 upward
        logic       grant;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Raise valid, then wait (bounded) until ready. On return we are just after
    // a falling edge, and the next rising edge is the accepting edge.
    task automatic request(input logic id, input logic [7:0] d);
        bit ok;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("request_ready", 32'(ok), 32'd1);
    endtask

    // Follows a frame cycle by cycle from the first cycle after acceptance
    // through the IDLE cycle that follows it (defaults: 44 busy cycles).
    task automatic check_frame(input logic [9:0] frame, input logic grant, input string tag);
        for (int off = 0; off <= 44; off++) begin
            @(negedge clk);
            if (off == 0) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                req0_data  = 8'h00; req1_data  = 8'h00;
            end
            check({tag, "_line"}, 32'(pulse_out), 32'((off < 40) ? frame[off/4] : 1'b1));
            check({tag, "_busy"}, 32'(busy), 32'(off < 44));
            check({tag, "_grant"}, 32'(grant_id), 32'(grant));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc_n[$];
        logic       acc_id[$];
        int         off;
        logic [9:0] cur;
        logic [7:0] exp_d;

        vecs[0] = '{id: 1'b0, data: 8'h46, frame: 10'b1010001100, grant: 1'b0};
        vecs[1] = '{id: 1'b1, data: 8'hA5, frame: 10'b1101001010, grant: 1'b1};
        vecs[2] = '{id: 1'b1, data: 8'h3C, frame: 10'b1001111000, grant: 1'b1};
        vecs[3] = '{id: 1'b0, data: 8'h00, frame: 10'b1000000000, grant: 1'b0};
        vecs[4] = '{id: 1'b0, data: 8'hFF, frame: 10'b1111111110, grant: 1'b0};

        // Reset with both requesters valid
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'hA5;
        req1_valid = 1'b1; req1_data = 8'h3C;
        c_req0_valid = 1'b0; c_req0_data = 8'h00;
        c_req1_valid = 1'b0; c_req1_data = 8'h00;
        #12;
        check("rst_pulse", 32'(pulse_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready0", 32'(req0_ready), 32'd1);
        check("rel_ready1", 32'(req1_ready), 32'd0);

        // Contention: both held valid, accepting edge follows cycle n
        off = -1;
        cur = 10'b1101001010;
        for (int n = 0; n < 180; n++) begin
            if (n > 0) @(negedge clk);
            if (off >= 0) begin
                check("cont_line", 32'(pulse_out), 32'((off < 40) ? cur[off/4] : 1'b1));
                check("cont_busy", 32'(busy), 32'(off < 44));
                off++;
            end
            check("cont_ready_excl", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_ready || req1_ready) begin
                acc_n.push_back(n);
                acc_id.push_back(req1_ready);
                cur = req1_ready ? 10'b1001111000 : 10'b1101001010;
                off = 0;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_acc_count", 32'(acc_n.size()), 32'd4);
        if (acc_n.size() == 4) begin
            check("cont_grant0", 32'(acc_id[0]), 32'd0);
            check("cont_grant1", 32'(acc_id[1]), 32'd1);
            check("cont_grant2", 32'(acc_id[2]), 32'd0);
            check("cont_grant3", 32'(acc_id[3]), 32'd1);
            for (int k = 1; k < 4; k++)
                check("cont_period", 32'(acc_n[k] - acc_n[k-1]), 32'd45);
        end

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            request(vecs[v].id, vecs[v].data);
            check_frame(vecs[v].frame, vecs[v].grant, "vec");
        end

        // Hold-off: req1 appears mid-frame, data changes every cycle
        request(1'b0, 8'h46);
        exp_d = 8'h00;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 1) req0_valid = 1'b0;
            if (i >= 10) begin req1_valid = 1'b1; req1_data = 8'(i * 37 + 5); end
            #1;
            if (i < 45) begin
                check("hold_ready1", 32'(req1_ready), 32'd0);
                check("hold_busy", 32'(busy), 32'd1);
            end else begin
                check("hold_ready1_idle", 32'(req1_ready), 32'd1);
                check("hold_busy_idle", 32'(busy), 32'd0);
                exp_d = req1_data;
            end
        end
        check_frame({1'b1, exp_d, 1'b0}, 1'b1, "hold");

        // Reset at cycle 20 of a frame
        request(1'b0, 8'h46);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) req0_valid = 1'b0;
        end
        check("mid_pre_line", 32'(pulse_out), 32'd0);
        check("mid_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pulse", 32'(pulse_out), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        request(1'b1, 8'h81);
        check_frame(10'b1100000010, 1'b1, "after_rst");

        // Corner instance: 0xFF back to back
        acc_n.delete();
        @(negedge clk);
        c_req0_valid = 1'b1; c_req0_data = 8'hFF;
        #1;
        off = -1;
        for (int n = 0; n < 33; n++) begin
            if (n > 0) @(negedge clk);
            if (off >= 0) begin
                check("corner_line", 32'(c_pulse_out), 32'(off != 0));
                check("corner_busy", 32'(c_busy), 32'(off < 10));
                off++;
            end
            check("corner_ready1", 32'(c_req1_ready), 32'd0);
            if (c_req0_ready) begin
                acc_n.push_back(n);
                off = 0;
            end
        end
        @(negedge clk);
        c_req0_valid = 1'b0;
        check("corner_grant", 32'(c_grant_id), 32'd0);
        check("corner_acc_count", 32'(acc_n.size()), 32'd3);
        if (acc_n.size() == 3) begin
            for (int k = 1; k < 3; k++)
                check("corner_period", 32'(acc_n[k] - acc_n[k-1]), 32'd11);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
